trace_commit_streamer: RTL and testbench
========================================

// Module: trace_commit_streamer
// PURPOSE
//  Producer side of the instruction-trace path. Captures retired instructions from the WB stage
//  into a record FIFO. Serializes each record as a 4-beat valid/ready word stream for an offload
//  sink (bench monitor, trace port or log DMA). Overflow drops whole records; sequence gaps and a
//  lost flag expose every drop.
// PARAMETERS
//  XLEN   32  datapath width; all beats are XLEN bits
//  DEPTH  8   record FIFO entries; power of 2, >= 2
// PORTS
//  ACLK            in   1     clock, all state on posedge
//  ARESETn         in   1     async active-low reset
//  trace_en        in   1     1 = capture retires; 0 = no new captures, FIFO keeps draining
//  retire_valid    in   1     one instruction retires this cycle
//  retire_pc       in   XLEN  PC of retiring inst
//  retire_inst     in   32    raw instruction word
//  retire_rd_idx   in   5     destination register index
//  retire_rd_we    in   1     register-file write enable
//  retire_rd_data  in   XLEN  writeback data (don't-care when rd_we=0)
//  trc_valid       out  1     beat valid
//  trc_ready       in   1     sink accepts beat
//  trc_data        out  XLEN  beat payload
//  trc_last        out  1     final (4th) beat of record
//  drop_cnt        out  32    saturating count of dropped records
//  fifo_level      out  $clog2(DEPTH)+1  current FIFO occupancy
// BEHAVIOUR
//  Reset (ARESETn=0, async): FIFO empty, seq=0, lost=0, FSM=IDLE, trc_valid=0, trc_data=0,
//   trc_last=0, drop_cnt=0, fifo_level=0.
//  Capture (retire_valid & trace_en, sampled on posedge):
//   - seq_q (16b) stamps the record, then increments (wraps 0xFFFF->0) whether stored or dropped
//   - full = (level==DEPTH) before any same-cycle pop; full -> drop: drop_cnt+=1 (sat 0xFFFFFFFF),
//     lost<=1; else push {seq, rd_idx, rd_we, lost, pc, inst, rd_data}, lost<=0
//   - trace_en=0 or retire_valid=0: no push, seq unchanged
//  Record beats, in order:
//   0 HDR : [31:16]=seq, [15:11]=rd_idx, [10]=rd_we, [9]=lost, [8:0]=0
//   1 PC  : retire_pc
//   2 INST: retire_inst
//   3 DATA: rd_data if rd_we else 0; trc_last=1 on this beat only
//  FSM: IDLE -> HDR -> PC -> INST -> DATA
//   - IDLE: if FIFO non-empty, pop head into output record register, go HDR
//   - HDR/PC/INST: advance only on trc_valid & trc_ready
//   - DATA: on handshake, if FIFO non-empty pop next record and go HDR (back-to-back, no bubble);
//     else go IDLE
//   - trc_valid=1 exactly in HDR..DATA
//  Stream rules:
//   - trc_data and trc_last hold stable while trc_valid & !trc_ready
//   - trc_valid never drops without a handshake
//  Latency: retire sampled at edge N with FIFO empty and FSM IDLE -> HDR beat valid from edge N+1.
//  Simultaneous push+pop with FIFO not full: both occur, level unchanged.
//  Push when full: always drops, even if a pop happens the same cycle.
//  Dropped records are never partially emitted. A record in flight always completes regardless
//   of trace_en.
//  fifo_level counts FIFO entries only, excluding the record being serialized.
//  Reset mid-record: stream aborts immediately; trc_valid=0 in the reset cycle.
// TESTING
//  1 Single retire pc=0x100 inst=0x00500093 rd=1 we=1 data=5, ready=1 -> beats 0x00000C00,
//    0x100, 0x00500093, 0x5; last only on beat 4; next retire has seq=1.
//  2 Ready held 0 for 3 cycles mid-PC beat -> trc_data stays 0x100, valid stays 1; resumes in order.
//  3 DEPTH=8, ready=0, 12 consecutive retires -> 8 stored (beyond in-flight), drop_cnt=3 or 4 per
//    pop timing; next accepted record has lost=1 and seq gap; later records lost=0.
//  4 Back-to-back 3 records, ready=1 -> 12 contiguous beats, no idle cycle, seq 0,1,2.
//  5 rd_we=0 store with rd_data=0xDEAD -> DATA beat 0; trace_en=0 retires -> no records, seq frozen.
//  6 ARESETn pulsed low during INST beat -> valid=0 immediately; drop_cnt=0; next record seq=0.

Source files
------------

// File: rtl/trace_commit_streamer_if.sv
// ----------------------------------------------------------------------------
// trace_commit_streamer_if
//   Valid/ready word stream carrying serialized trace records.
//   trc_valid : beat valid (driven by the producer)
//   trc_ready : beat accepted (driven by the sink)
//   trc_data  : beat payload, XLEN bits
//   trc_last  : marks the final beat of a record
//   Modports: master = producer side, slave = sink side.
// ----------------------------------------------------------------------------
interface trace_commit_streamer_if #(
    parameter int XLEN = 32
);
    logic            trc_valid;
    logic            trc_ready;
    logic [XLEN-1:0] trc_data;
    logic            trc_last;

    modport master (
        output trc_valid,
        output trc_data,
        output trc_last,
        input  trc_ready
    );

    modport slave (
        input  trc_valid,
        input  trc_data,
        input  trc_last,
        output trc_ready
    );
endinterface

// File: rtl/trace_commit_streamer.sv
// ----------------------------------------------------------------------------
// trace_commit_streamer
//   Captures retired instructions from WB into a record FIFO and serializes
//   each record as four beats (HDR, PC, INST, DATA) on a valid/ready stream.
//   When the FIFO is full a retire is dropped as a whole record; the sequence
//   number still advances and the next stored record carries the lost flag.
//
//   Ports
//     ACLK, ARESETn    clock, asynchronous active-low reset
//     trace_en         capture enable (in-flight/queued records still drain)
//     retire_*         retire-port sample: valid, pc, inst, rd_idx, rd_we, rd_data
//     trc              record stream (master modport)
//     drop_cnt         saturating count of dropped records
//     fifo_level       FIFO occupancy, excluding the record being serialized
// ----------------------------------------------------------------------------
module trace_commit_streamer #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 8
) (
    input  logic                     ACLK,
    input  logic                     ARESETn,
    input  logic                     trace_en,
    input  logic                     retire_valid,
    input  logic [XLEN-1:0]          retire_pc,
    input  logic [31:0]              retire_inst,
    input  logic [4:0]               retire_rd_idx,
    input  logic                     retire_rd_we,
    input  logic [XLEN-1:0]          retire_rd_data,
    trace_commit_streamer_if.master  trc,
    output logic [31:0]              drop_cnt,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [15:0]     seq;
        logic [4:0]      rd_idx;
        logic            rd_we;
        logic            lost;
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
        logic [XLEN-1:0] rd_data;
    } rec_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_PC,
        ST_INST,
        ST_DATA
    } state_t;

    rec_t        mem [DEPTH];
    rec_t        rec_reg;
    rec_t        rec_new;
    logic [AW:0] wr_ptr_reg;
    logic [AW:0] rd_ptr_reg;
    logic [AW:0] level;
    logic [15:0] seq_reg;
    logic        lost_reg;
    logic [31:0] drop_cnt_reg;
    state_t      state_reg;
    state_t      state_next;

    logic        capture;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;
    logic        valid_c;
    logic [31:0] hdr_word;

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign level   = wr_ptr_reg - rd_ptr_reg;
    assign full    = (level == FULL_LVL);
    assign empty   = (level == '0);
    assign capture = retire_valid & trace_en;
    // Full is judged before any same-cycle pop, so a full FIFO always drops.
    assign push    = capture & ~full;

    // Writeback data is zeroed at capture when the instruction does not write rd.
    always_comb begin
        rec_new         = '0;
        rec_new.seq     = seq_reg;
        rec_new.rd_idx  = retire_rd_idx;
        rec_new.rd_we   = retire_rd_we;
        rec_new.lost    = lost_reg;
        rec_new.pc      = retire_pc;
        rec_new.inst    = retire_inst;
        rec_new.rd_data = retire_rd_we ? retire_rd_data : '0;
    end

    // Record storage; the pop into rec_reg is the registered read port.
    always_ff @(posedge ACLK) begin
        if (push) begin
            mem[wr_ptr_reg[AW-1:0]] <= rec_new;
        end
    end

    // Beat sequencer: next state, pop request and stream valid.
    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
        valid_c    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = ST_HDR;
                end
            end
            ST_HDR: begin
                valid_c = 1'b1;
                if (trc.trc_ready) state_next = ST_PC;
            end
            ST_PC: begin
                valid_c = 1'b1;
                if (trc.trc_ready) state_next = ST_INST;
            end
            ST_INST: begin
                valid_c = 1'b1;
                if (trc.trc_ready) state_next = ST_DATA;
            end
            ST_DATA: begin
                valid_c = 1'b1;
                if (trc.trc_ready) begin
                    // Chain straight into the next record to avoid a bubble.
                    if (!empty) begin
                        pop        = 1'b1;
                        state_next = ST_HDR;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_reg    <= ST_IDLE;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            seq_reg      <= '0;
            lost_reg     <= 1'b0;
            drop_cnt_reg <= '0;
            rec_reg      <= '0;
        end else begin
            state_reg <= state_next;
            if (capture) begin
                seq_reg <= seq_reg + 16'd1;
                if (full) begin
                    lost_reg <= 1'b1;
                    if (drop_cnt_reg != 32'hFFFF_FFFF) begin
                        drop_cnt_reg <= drop_cnt_reg + 32'd1;
                    end
                end else begin
                    lost_reg <= 1'b0;
                end
            end
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
                rec_reg    <= mem[rd_ptr_reg[AW-1:0]];
            end
        end
    end

    assign hdr_word = {rec_reg.seq, rec_reg.rd_idx, rec_reg.rd_we, rec_reg.lost, 9'b0};

    // Beat payload is a pure function of state and the held record, so it
    // stays stable for as long as the sink stalls.
    always_comb begin
        trc.trc_data = '0;
        trc.trc_last = 1'b0;
        case (state_reg)
            ST_HDR:  trc.trc_data = XLEN'(hdr_word);
            ST_PC:   trc.trc_data = rec_reg.pc;
            ST_INST: trc.trc_data = XLEN'(rec_reg.inst);
            ST_DATA: begin
                trc.trc_data = rec_reg.rd_data;
                trc.trc_last = 1'b1;
            end
            default: ;
        endcase
    end

    assign trc.trc_valid = valid_c;
    assign drop_cnt      = drop_cnt_reg;
    assign fifo_level    = level;

endmodule

// File: tb/tb_trace_commit_streamer.sv
module tb_trace_commit_streamer;
    localparam int XLEN  = 32;
    localparam int DEPTH = 8;

    logic        ACLK    = 1'b0;
    logic        ARESETn = 1'b0;
    logic        trace_en = 1'b1;
    logic        retire_valid = 1'b0;
    logic [31:0] retire_pc = '0;
    logic [31:0] retire_inst = '0;
    logic [4:0]  retire_rd_idx = '0;
    logic        retire_rd_we = 1'b0;
    logic [31:0] retire_rd_data = '0;
    logic [31:0] drop_cnt;
    logic [3:0]  fifo_level;

    trace_commit_streamer_if #(.XLEN(XLEN)) trc ();

    trace_commit_streamer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .ACLK           (ACLK),
        .ARESETn        (ARESETn),
        .trace_en       (trace_en),
        .retire_valid   (retire_valid),
        .retire_pc      (retire_pc),
        .retire_inst    (retire_inst),
        .retire_rd_idx  (retire_rd_idx),
        .retire_rd_we   (retire_rd_we),
        .retire_rd_data (retire_rd_data),
        .trc            (trc),
        .drop_cnt       (drop_cnt),
        .fifo_level     (fifo_level)
    );

    always #5 ACLK = ~ACLK;

    int total = 0;
    int bad   = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [15:0] seq;
        logic [4:0]  rd;
        logic        we;
        logic        lost;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] data;
    } mrec_t;

    mrec_t       mq[$];
    mrec_t       m_cur;
    mrec_t       m_new;
    bit          m_busy = 0;
    int          m_beat = 0;
    logic [15:0] m_seq  = '0;
    bit          m_lost = 0;
    logic [31:0] m_drop = '0;
    int          m_pre;

    function automatic logic [31:0] beat_data(mrec_t r, int idx);
        case (idx)
            0:       return {r.seq, r.rd, r.we, r.lost, 9'b0};
            1:       return r.pc;
            2:       return r.inst;
            default: return r.we ? r.data : 32'h0;
        endcase
    endfunction

    initial begin
        forever begin
            @(posedge ACLK or negedge ARESETn);
            if (!ARESETn) begin
                mq.delete();
                m_busy = 0;
                m_beat = 0;
                m_seq  = '0;
                m_lost = 0;
                m_drop = '0;
            end else begin
                m_pre = mq.size();
                if (!m_busy) begin
                    if (m_pre > 0) begin
                        m_cur  = mq.pop_front();
                        m_busy = 1;
                        m_beat = 0;
                    end
                end else if (trc.trc_ready) begin
                    if (m_beat < 3) begin
                        m_beat++;
                    end else if (m_pre > 0) begin
                        m_cur  = mq.pop_front();
                        m_beat = 0;
                    end else begin
                        m_busy = 0;
                    end
                end
                if (retire_valid && trace_en) begin
                    if (m_pre == DEPTH) begin
                        if (m_drop != 32'hFFFF_FFFF) m_drop++;
                        m_lost = 1;
                    end else begin
                        m_new.seq  = m_seq;
                        m_new.rd   = retire_rd_idx;
                        m_new.we   = retire_rd_we;
                        m_new.lost = m_lost;
                        m_new.pc   = retire_pc;
                        m_new.inst = retire_inst;
                        m_new.data = retire_rd_data;
                        mq.push_back(m_new);
                        m_lost = 0;
                    end
                    m_seq++;
                end
            end
        end
    end

    // ---------------- per-cycle compare and beat log ----------------
    logic [32:0] seen[$];
    time         hs_first;
    time         hs_last;

    initial begin
        forever begin
            @(negedge ACLK);
            if (!ARESETn) begin
                check("rst_valid", trc.trc_valid, 0);
                check("rst_data", trc.trc_data, 0);
                check("rst_last", trc.trc_last, 0);
                check("rst_drop", drop_cnt, 0);
                check("rst_level", fifo_level, 0);
            end else begin
                check("valid", trc.trc_valid, m_busy);
                if (m_busy) begin
                    check("data", trc.trc_data, beat_data(m_cur, m_beat));
                    check("last", trc.trc_last, (m_beat == 3));
                end
                check("drop_cnt", drop_cnt, m_drop);
                check("level", fifo_level, mq.size());
                if (trc.trc_valid && trc.trc_ready) begin
                    if (seen.size() == 0) hs_first = $time;
                    hs_last = $time;
                    seen.push_back({trc.trc_last, trc.trc_data});
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(int n);
        repeat (n) @(posedge ACLK);
        #1;
    endtask

    task automatic do_reset();
        ARESETn      = 1'b0;
        retire_valid = 1'b0;
        trace_en     = 1'b1;
        trc.trc_ready = 1'b1;
        #1;
        check("rst_async_valid", trc.trc_valid, 0);
        check("rst_async_level", fifo_level, 0);
        tick(2);
        ARESETn = 1'b1;
        seen.delete();
    endtask

    task automatic retire(logic [31:0] pc, logic [31:0] inst, logic [4:0] rd,
                          logic we, logic [31:0] data);
        retire_valid   = 1'b1;
        retire_pc      = pc;
        retire_inst    = inst;
        retire_rd_idx  = rd;
        retire_rd_we   = we;
        retire_rd_data = data;
        tick(1);
        retire_valid   = 1'b0;
    endtask

    task automatic drain(int limit);
        int n = 0;
        while ((trc.trc_valid || fifo_level != 0) && n < limit) begin
            tick(1);
            n++;
        end
        check("drain_timeout", (n < limit), 1);
        tick(1);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        trc.trc_ready = 1'b1;
        // 1: single record, literal beats
        do_reset();
        retire(32'h100, 32'h0050_0093, 5'd1, 1'b1, 32'h5);
        drain(50);
        check("t1_nbeats", seen.size(), 4);
        check("t1_hdr", seen[0], {1'b0, 32'h0000_0C00});
        check("t1_pc", seen[1], {1'b0, 32'h0000_0100});
        check("t1_inst", seen[2], {1'b0, 32'h0050_0093});
        check("t1_data", seen[3], {1'b1, 32'h0000_0005});
        seen.delete();
        retire(32'h104, 32'h0000_0013, 5'd0, 1'b0, 32'h0);
        drain(50);
        check("t1_seq1", seen[0][31:16], 16'd1);

        // 2: stall during the PC beat
        do_reset();
        retire(32'h100, 32'h0050_0093, 5'd1, 1'b1, 32'h5);
        tick(2);
        trc.trc_ready = 1'b0;
        tick(3);
        check("t2_hold_valid", trc.trc_valid, 1);
        check("t2_hold_data", trc.trc_data, 32'h100);
        trc.trc_ready = 1'b1;
        drain(50);
        check("t2_nbeats", seen.size(), 4);
        check("t2_pc", seen[1], {1'b0, 32'h0000_0100});
        check("t2_data", seen[3], {1'b1, 32'h0000_0005});

        // 3: overflow with sink stalled
        do_reset();
        trc.trc_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            retire(32'h200 + 32'(4 * i), 32'h13 + 32'(i), 5'(i + 1), 1'b1, 32'(i));
        end
        check("t3_drop", drop_cnt, 32'd3);
        check("t3_level", fifo_level, 4'd8);
        trc.trc_ready = 1'b1;
        drain(200);
        check("t3_nbeats", seen.size(), 36);
        check("t3_last_kept_seq", seen[32][31:16], 16'd8);
        seen.delete();
        retire(32'h300, 32'h13, 5'd3, 1'b1, 32'h33);
        retire(32'h304, 32'h13, 5'd4, 1'b1, 32'h44);
        drain(50);
        check("t3_gap_seq", seen[0][31:16], 16'd12);
        check("t3_gap_lost", seen[0][9], 1'b1);
        check("t3_next_seq", seen[4][31:16], 16'd13);
        check("t3_next_lost", seen[4][9], 1'b0);
        check("t3_drop_after", drop_cnt, 32'd3);

        // 4: three back-to-back records, no bubble
        do_reset();
        retire(32'h400, 32'h13, 5'd1, 1'b1, 32'h1);
        retire(32'h404, 32'h13, 5'd2, 1'b1, 32'h2);
        retire(32'h408, 32'h13, 5'd3, 1'b1, 32'h3);
        drain(50);
        check("t4_nbeats", seen.size(), 12);
        check("t4_seq0", seen[0][31:16], 16'd0);
        check("t4_seq1", seen[4][31:16], 16'd1);
        check("t4_seq2", seen[8][31:16], 16'd2);
        check("t4_contig", (hs_last - hs_first) / 10, 11);

        // 5: no-write instruction, then disabled capture
        do_reset();
        retire(32'h500, 32'h0011_2023, 5'd0, 1'b0, 32'hDEAD);
        drain(50);
        check("t5_hdr", seen[0], {1'b0, 32'h0});
        check("t5_data", seen[3], {1'b1, 32'h0});
        trace_en = 1'b0;
        retire(32'h504, 32'h13, 5'd1, 1'b1, 32'h1);
        retire(32'h508, 32'h13, 5'd1, 1'b1, 32'h1);
        tick(5);
        check("t5_no_rec", seen.size(), 4);
        check("t5_level", fifo_level, 4'd0);
        trace_en = 1'b1;
        retire(32'h50C, 32'h13, 5'd2, 1'b1, 32'h2);
        drain(50);
        check("t5_seq_frozen", seen[4][31:16], 16'd1);

        // 6: reset during the INST beat
        do_reset();
        retire(32'h600, 32'hABCD_0013, 5'd2, 1'b1, 32'h7);
        tick(3);
        trc.trc_ready = 1'b0;
        check("t6_inst_beat", trc.trc_data, 32'hABCD_0013);
        #2;
        ARESETn = 1'b0;
        #1;
        check("t6_valid_rst", trc.trc_valid, 0);
        check("t6_drop_rst", drop_cnt, 32'd0);
        tick(1);
        ARESETn = 1'b1;
        trc.trc_ready = 1'b1;
        seen.delete();
        retire(32'h700, 32'h13, 5'd5, 1'b1, 32'h9);
        drain(50);
        check("t6_seq0", seen[0][31:16], 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
